// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive byte packer.
//   SPI_BYTES_PER_WORD    : bytes packed into one AXI-Stream word
//   spi_rx_packer_state_t : packer FSM state encoding
//   keep_mask()           : contiguous byte-valid mask for a byte count
package spi_pkg;

  localparam int unsigned SPI_BYTES_PER_WORD = 4;
  localparam int unsigned SPI_MASK_W         = SPI_BYTES_PER_WORD + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    HOLD,
    OUT
  } spi_rx_packer_state_t;

  // (1 << n) - 1, computed one bit wider so n == 4 yields all ones
  function automatic logic [SPI_BYTES_PER_WORD-1:0] keep_mask(input logic [2:0] n);
    logic [SPI_MASK_W-1:0] one_hot;
    one_hot   = SPI_MASK_W'(1) << n;
    keep_mask = SPI_BYTES_PER_WORD'(one_hot - SPI_MASK_W'(1));
  endfunction

endpackage

// File: rtl/spi_rx_packer.sv
// Packs bytes from the SPI read-data FIFO into 32-bit AXI-Stream words.
// A rising edge on read_complete ends the packet: once the FIFO drains the
// last (possibly partial) word goes out with tlast set.
//
// Ports
//   clk, rstn        : clock, synchronous active-low reset
//   fifo_not_empty   : FIFO holds at least one byte
//   fifo_dout        : FIFO data, valid one cycle after fifo_rd_en
//   fifo_rd_en       : FIFO pop strobe (one outstanding read at most)
//   read_complete    : end-of-burst level, rising edge is the event
//   m_axis_*         : AXI-Stream master (tdata, tkeep, tvalid, tlast, tready)
//   last_pkt_bytes   : byte count of the last completed packet
//
// Build option: define SPI_RX_PACKER_BYTE_COUNT_EN to generate the packet byte
// counter; otherwise last_pkt_bytes is tied to zero.
module spi_rx_packer
  import spi_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               fifo_not_empty,
  input  logic [7:0]         fifo_dout,
  output logic               fifo_rd_en,
  input  logic               read_complete,
  output logic [31:0]        m_axis_tdata,
  output logic [3:0]         m_axis_tkeep,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic [COUNT_W-1:0] last_pkt_bytes
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = BYTE_W * SPI_BYTES_PER_WORD;
  localparam int unsigned KEEP_W = SPI_BYTES_PER_WORD;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(SPI_BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SPI_BYTES_PER_WORD);

  spi_rx_packer_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              rd_en_q, rd_en_d;
  logic              flush_q, flush_d;
  logic              rc_q;
  logic              rc_rise;
  logic              hs;

  assign rc_rise = read_complete & ~rc_q;
  assign hs      = valid_q & m_axis_tready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rd_en_q <= 1'b0;
      flush_q <= 1'b0;
      rc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      rd_en_q <= rd_en_d;
      flush_q <= flush_d;
      rc_q    <= read_complete;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    last_d  = last_q;
    rd_en_d = 1'b0;
    flush_d = flush_q | rc_rise;

    unique case (state_q)
      IDLE: begin
        if (cnt_q < FULL_CNT && fifo_not_empty) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end else if (flush_q && cnt_q != '0) begin
          state_d = OUT;
          valid_d = 1'b1;
          last_d  = 1'b1;
          keep_d  = keep_mask(cnt_q);
        end else if (flush_q) begin
          // empty packet: drop the flush, keep any edge seen this cycle
          flush_d = rc_rise;
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d[{cnt_q[1:0], 3'b000} +: BYTE_W] = fifo_dout;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_LANE) begin
          state_d = HOLD;
        end else if (fifo_not_empty) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // more data means this word cannot be the packet end
        if (fifo_not_empty) begin
          state_d = OUT;
          valid_d = 1'b1;
          last_d  = 1'b0;
          keep_d  = '1;
        end else if (flush_q) begin
          state_d = OUT;
          valid_d = 1'b1;
          last_d  = 1'b1;
          keep_d  = '1;
        end
      end
      OUT: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          keep_d  = '0;
          data_d  = '0;
          cnt_d   = '0;
          // an edge coinciding with the tlast beat belongs to the next packet
          if (last_q) flush_d = rc_rise;
          if (fifo_not_empty) begin
            state_d = FETCH;
            rd_en_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_rd_en    = rd_en_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;

`ifdef SPI_RX_PACKER_BYTE_COUNT_EN
  localparam int unsigned SUM_W = COUNT_W + 1;

  logic [COUNT_W-1:0] bc_q, bc_d;
  logic [COUNT_W-1:0] lpb_q, lpb_d;
  logic [SUM_W-1:0]   sum;
  logic [COUNT_W-1:0] sat;

  // Saturating per-packet byte accumulator
  always_comb begin
    sum = SUM_W'(bc_q);
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      sum = sum + SUM_W'(keep_q[i]);
    end
    sat   = sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
    bc_d  = bc_q;
    lpb_d = lpb_q;
    if (hs) begin
      if (last_q) begin
        lpb_d = sat;
        bc_d  = '0;
      end else begin
        bc_d  = sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bc_q  <= '0;
      lpb_q <= '0;
    end else begin
      bc_q  <= bc_d;
      lpb_q <= lpb_d;
    end
  end

  assign last_pkt_bytes = lpb_q;
`else
  assign last_pkt_bytes = '0;
`endif

endmodule
